// File: rtl/dsp_mul_add_tree_if.sv
// Handshake bundle for dsp_mul_add_tree: packed operand beats in, lane sums out.
interface dsp_mul_add_tree_if #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned A_W       = 18,
  parameter int unsigned B_W       = 18,
  parameter int unsigned D_W       = 38
);
  logic [NUM_LANES*A_W-1:0] in_a;
  logic [NUM_LANES*B_W-1:0] in_b;
  logic                     in_last;
  logic                     in_valid;
  logic                     in_ready;
  logic [D_W-1:0]           out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_a, in_b, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_a, in_b, in_last, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/dsp_mul_add_tree.sv
// N-lane multiply-add pipeline (sum of a[i]*b[i]) with registered adder tree and global stall.
// Define DSP_MUL_ADD_ACC_EN to add a group accumulator closed by in_last (out_data becomes ACC_W wide).
module dsp_mul_add_tree #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned A_W       = 18,
  parameter int unsigned B_W       = 18,
  parameter int unsigned SIGNED    = 0,
  parameter int unsigned ACC_W     = 48
) (
  input logic              clk,
  input logic              rst,
  dsp_mul_add_tree_if.slave bus
);
  localparam int unsigned LVL    = $clog2(NUM_LANES);
  localparam int unsigned OUT_W  = A_W + B_W + LVL;
  localparam int unsigned LEAVES = 1 << LVL;
  localparam int unsigned NODES  = 2 * LEAVES - 1;
  localparam int unsigned ROOT   = NODES - 1;
  localparam bit          SX     = (SIGNED != 0);

  if (NUM_LANES < 1 || ACC_W < OUT_W) begin : g_bad_cfg
    $error("dsp_mul_add_tree: need NUM_LANES >= 1 and ACC_W >= OUT_W");
  end

  // Tree nodes live in one array, level k starting at lvl_off(k); level 0 holds the products.
  function automatic int unsigned lvl_off(input int unsigned k);
    return 2 * LEAVES - 2 * (LEAVES >> k);
  endfunction

  logic                     ce;
  logic                     v0;
  logic [NUM_LANES*A_W-1:0] a_q;
  logic [NUM_LANES*B_W-1:0] b_q;
  logic [OUT_W-1:0]         prod [NUM_LANES];
  logic [OUT_W-1:0]         node [NODES];
  logic [LVL:0]             tv;

  assign ce           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = ce;

  // Operands are extended to the full result width first, so every later add is exact.
  always_comb begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      prod[i] = {{(OUT_W-A_W){SX & a_q[i*A_W+A_W-1]}}, a_q[i*A_W +: A_W]} *
                {{(OUT_W-B_W){SX & b_q[i*B_W+B_W-1]}}, b_q[i*B_W +: B_W]};
    end
  end

  always_ff @(posedge clk) begin
    if (ce) begin
      a_q <= bus.in_a;
      b_q <= bus.in_b;
      for (int unsigned i = 0; i < NUM_LANES; i++) node[i] <= prod[i];
      for (int unsigned i = NUM_LANES; i < LEAVES; i++) node[i] <= '0;
      for (int unsigned k = 1; k <= LVL; k++) begin
        for (int unsigned j = 0; j < (LEAVES >> k); j++) begin
          node[lvl_off(k)+j] <= node[lvl_off(k-1)+2*j] + node[lvl_off(k-1)+2*j+1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0;
      tv <= '0;
    end else if (ce) begin
      v0    <= bus.in_valid;
      tv[0] <= v0;
      for (int unsigned k = 1; k <= LVL; k++) tv[k] <= tv[k-1];
    end
  end

`ifndef DSP_MUL_ADD_ACC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else if (ce) begin
      bus.out_valid <= tv[LVL];
      if (tv[LVL]) bus.out_data <= node[ROOT];
    end
  end
`else
  logic             l0;
  logic [LVL:0]     tl;
  logic             r_v;
  logic             r_l;
  logic [ACC_W-1:0] r_d;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] root_x;
  logic [ACC_W-1:0] sum;

  always_comb begin
    root_x = SX ? ACC_W'($signed(node[ROOT])) : ACC_W'(node[ROOT]);
    sum    = acc + r_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l0 <= 1'b0;
      tl <= '0;
    end else if (ce) begin
      l0    <= bus.in_last;
      tl[0] <= l0;
      for (int unsigned k = 1; k <= LVL; k++) tl[k] <= tl[k-1];
    end
  end

  // Extra stage r_* registers the tree result so the accumulate add stays off the tree path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v           <= 1'b0;
      r_l           <= 1'b0;
      r_d           <= '0;
      acc           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else if (ce) begin
      r_v           <= tv[LVL];
      r_l           <= tl[LVL];
      if (tv[LVL]) r_d <= root_x;
      bus.out_valid <= r_v && r_l;
      if (r_v) begin
        if (r_l) begin
          bus.out_data <= sum;
          acc          <= '0;
        end else begin
          acc <= sum;
        end
      end
    end
  end
`endif
endmodule
